// File: rtl/lu_truth_table_scanner.sv
// Self-test sequencer for the 2-input logic unit: sweeps all op/operand
// vectors, collects the result bits into a truth table and checks it.
module lu_truth_table_scanner #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'hE187
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        z_in,
   output logic        x_out,
   output logic        y_out,
   output logic        s1_out,
   output logic        s2_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic        err
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [3:0] WLOAD = 4'(SETTLE - 1);

   state_t      state;
   logic [3:0]  idx;
   logic [3:0]  wcnt;
   logic [15:0] table_next;

   // idx is a register and is forced to 0 outside a scan, so the
   // vector outputs are registered and idle at 0.
   assign {s2_out, s1_out, x_out, y_out} = idx;

   always_comb begin
      table_next      = table_out;
      table_next[idx] = z_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= 4'd0;
         wcnt      <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_out <= 16'h0000;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= SCAN;
                  busy      <= 1'b1;
                  idx       <= 4'd0;
                  table_out <= 16'h0000;
                  err       <= 1'b0;
                  wcnt      <= WLOAD;
               end
            end
            SCAN: begin
               if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  table_out <= table_next;
                  if (idx != 4'd15) begin
                     idx  <= idx + 4'd1;
                     wcnt <= WLOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     err   <= (table_next != EXPECTED);
                     idx   <= 4'd0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lu_truth_table_scanner.sv
// Randomized bench for lu_truth_table_scanner with a behavioural LU model,
// covering SETTLE=1 and SETTLE=3 instances.
module tb_lu_truth_table_scanner;

   localparam logic [15:0] GOLD = 16'hE187;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start1 = 1'b0, start3 = 1'b0;
   logic z1 = 1'b0, z3 = 1'b0;
   logic x1, y1, a1, b1, busy1, done1, err1;
   logic x3, y3, a3, b3, busy3, done3, err3;
   logic [15:0] tab1, tab3;

   int checks = 0;
   int errors = 0;
   int sel = 1;

   logic [3:0]  o_vec;
   logic        o_busy, o_done, o_err;
   logic [15:0] o_tab;

   always #5 clk = ~clk;

   lu_truth_table_scanner #(.SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .z_in(z1),
      .x_out(x1), .y_out(y1), .s1_out(a1), .s2_out(b1),
      .busy(busy1), .done(done1), .table_out(tab1), .err(err1)
   );

   lu_truth_table_scanner #(.SETTLE(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .z_in(z3),
      .x_out(x3), .y_out(y3), .s1_out(a3), .s2_out(b3),
      .busy(busy3), .done(done3), .table_out(tab3), .err(err3)
   );

   always_comb begin
      if (sel == 3) begin
         o_vec  = {b3, a3, x3, y3};
         o_busy = busy3;
         o_done = done3;
         o_err  = err3;
         o_tab  = tab3;
      end else begin
         o_vec  = {b1, a1, x1, y1};
         o_busy = busy1;
         o_done = done1;
         o_err  = err1;
         o_tab  = tab1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // mode 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 NOR/OR swapped
   function automatic logic lu_bit(input int mode, input int v);
      int op = v / 4;
      bit x = ((v / 2) % 2) == 1;
      bit y = (v % 2) == 1;
      if (mode == 1) return 1'b0;
      if (mode == 2) return 1'b1;
      if (mode == 3 && op == 2) return x | y;
      case (op)
         0:       return !(x && y);
         1:       return x && y;
         2:       return !(x || y);
         default: return x || y;
      endcase
   endfunction

   function automatic logic [15:0] model_table(input int mode);
      logic [15:0] t = '0;
      for (int v = 0; v < 16; v++) t[v] = lu_bit(mode, v);
      return t;
   endfunction

   task automatic set_start(input logic v);
      if (sel == 3) start3 = v; else start1 = v;
   endtask

   task automatic set_z(input logic v);
      if (sel == 3) z3 = v; else z1 = v;
   endtask

   task automatic run_scan(input int s, input int mode, input bit glitch,
                           input int restart_at, input bit already,
                           input bit chain);
      logic [15:0] et;
      int v;
      sel = s;
      et = model_table(mode);
      if (!already) begin
         @(negedge clk);
         set_start(1'b1);
      end
      @(posedge clk);
      #1;
      set_start(1'b0);
      check("scan_clear", o_tab, 16'h0000);
      for (int n = 0; n < 16 * s; n++) begin
         v = n / s;
         check("busy", o_busy, 1'b1);
         check("done_low", o_done, 1'b0);
         check("vector", o_vec, v);
         if (glitch && (n % s) != s - 1) set_z(1'($urandom));
         else set_z(lu_bit(mode, v));
         set_start(restart_at >= 0 && n == restart_at * s);
         @(posedge clk);
         #1;
      end
      set_start(1'b0);
      check("done", o_done, 1'b1);
      check("busy_end", o_busy, 1'b0);
      check("table", o_tab, et);
      check("err", o_err, et != GOLD);
      check("vec_idle", o_vec, 4'd0);
      if (chain) begin
         set_start(1'b1);
      end else begin
         @(posedge clk);
         #1;
         check("done_pulse", o_done, 1'b0);
         check("table_hold", o_tab, et);
         check("err_hold", o_err, et != GOLD);
      end
   endtask

   initial begin
      #12;
      check("rst_tab1", tab1, 16'h0000);
      check("rst_tab3", tab3, 16'h0000);
      check("rst_busy", {busy1, busy3, done1, done3}, 4'h0);
      check("rst_err", {err1, err3}, 2'b00);
      check("rst_vec", {b1, a1, x1, y1, b3, a3, x3, y3}, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      run_scan(1, 0, 0, -1, 0, 0);
      run_scan(1, 1, 0, -1, 0, 0);
      run_scan(1, 2, 0, -1, 0, 0);
      run_scan(3, 0, 1, -1, 0, 0);
      run_scan(1, 0, 0, 5, 0, 0);
      run_scan(1, 0, 0, -1, 0, 1);
      run_scan(1, 0, 0, -1, 1, 0);
      run_scan(1, 3, 0, -1, 0, 0);

      // asynchronous reset in the middle of vector 9
      sel = 1;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int n = 0; n < 9; n++) begin
         z1 = lu_bit(0, n);
         @(posedge clk);
         #1;
      end
      check("pre_rst_vec", o_vec, 4'd9);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", o_busy, 1'b0);
      check("mid_rst_vec", o_vec, 4'd0);
      check("mid_rst_tab", o_tab, 16'h0000);
      check("mid_rst_done", {o_done, o_err}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_idle", {o_busy, o_done}, 2'b00);
      run_scan(1, 0, 0, -1, 0, 0);

      for (int i = 0; i < 24; i++) begin
         int s = ($urandom_range(0, 1) == 1) ? 3 : 1;
         int m = $urandom_range(0, 3);
         bit g = (s == 3) && ($urandom_range(0, 1) == 1);
         int r = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : -1;
         run_scan(s, m, g, r, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lu_truth_table_scanner.md
Name: lu_truth_table_scanner

Overview:
- Sequential driver/collector that sits directly upstream of the 2-input logic unit (AND/NAND/OR/NOR selected by s1/s2 muxing) and consumes its single result bit.
- On a start request it sweeps all 4 op selects × 4 operand pairs, samples the LU output for each vector and packs a 16-bit truth table.
- Compares the table against a golden constant and flags a mismatch; used for self-test of the LU stage.

Parameters:
- SETTLE, 1, cycles a vector is held stable before z_in is sampled (legal range 1..15).
- EXPECTED, 16'hE187, golden truth table for a correct LU.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  scan request, sampled only in IDLE.
- z_in  input  1  LU final output (MUX3 result).
- x_out  output  1  operand x to LU.
- y_out  output  1  operand y to LU.
- s1_out  output  1  LU select s1 (0: NAND/NOR, 1: AND/OR).
- s2_out  output  1  LU select s2 (0: AND-group, 1: OR-group).
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the table is complete.
- table_out  output  16  collected truth table.
- err  output  1  table_out != EXPECTED; valid from done, held until next start.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high. Reset values: x_out=y_out=s1_out=s2_out=0, busy=0, done=0, table_out=16'h0000, err=0, state=IDLE, idx=0, wcnt=0.
- All outputs are registered; no combinational path from z_in or start to any output.
- Vector index idx[3:0] = {s2, s1, x, y}:
  - Driven outputs: s2_out=idx[3], s1_out=idx[2], x_out=idx[1], y_out=idx[0].
  - Sample of vector idx is written to table_out[idx].
  - Op nibbles with a correct LU: {s2,s1}=00 NAND→4'h7, 01 AND→4'h8, 10 NOR→4'h1, 11 OR→4'hE, giving 16'hE187.
- States: IDLE, SCAN.
- IDLE:
  - done is forced to 0 on any edge where it was 1.
  - If start=1 at an edge: state←SCAN, busy←1, idx←0, vector outputs←0, table_out←0, err←0, wcnt←SETTLE-1.
  - If start=0, all outputs hold, including table_out and err.
- SCAN:
  - At each edge, if wcnt≠0, decrement wcnt.
  - Otherwise, table_out[idx]←z_in, then:
    - If idx≠15: idx←idx+1, drive the new vector, wcnt←SETTLE-1.
    - If idx=15: state←IDLE, busy←0, done←1, err←(final table ≠ EXPECTED) using the just-sampled bit, vector outputs←0.
- Timing: a vector applied at edge E is sampled at edge E+SETTLE. If start is accepted at edge E0, the k-th sample (k=1..16) occurs at edge E0+k·SETTLE, and done is high for the cycle after edge E0+16·SETTLE.
- start while busy: ignored. It is not queued and does not restart the scan.
- start high in the cycle done is high: accepted at the next edge; done←0 and a new scan begins (back-to-back scans allowed).
- start held high continuously: scans repeat back to back.
- rst mid-scan: immediate return to the reset values; the partial table is discarded.
- idx does not wrap within a scan; the idx=15 sample always terminates the scan.

Test Plan:
- Ideal LU model on z_in, SETTLE=1, pulse start → busy for 16 cycles; vectors step 0..15 one per cycle; done pulses once; table_out=16'hE187, err=0.
- z_in stuck at 0, SETTLE=1 → table_out=16'h0000, err=1. z_in stuck at 1 → table_out=16'hFFFF, err=1.
- SETTLE=3, ideal LU → each vector held 3 cycles; done 48 cycles after the start edge; table_out=16'hE187; z_in glitches inside the first 2 cycles of a vector do not affect the result.
- Ideal LU; assert start again at vector 5 → no restart, done still at cycle 16. Assert start during the done cycle → second scan begins immediately, table_out cleared to 0 then ends 16'hE187.
- Assert rst asynchronously at vector 9 (between edges) → all outputs 0 immediately, busy=0, no done pulse; a subsequent start yields a full correct scan (16'hE187).
- LU model with NOR/OR swapped (op 10 returns OR) → table_out=16'hEE87, err=1.
